// File: rtl/shift_frame_ctrl_pkg.sv
// Shared state type, default parameters and counter sizing for the shift frame controller.
package shift_frame_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int   DEF_WIDTH      = 8;
   localparam int   DEF_DIV        = 4;
   localparam logic DEF_IDLE_LEVEL = 1'b1;

   // A divide-by-1 timer still needs a one-bit counter to stay well-formed.
   function automatic int div_cnt_width(input int div);
      return $clog2((div < 2) ? 2 : div);
   endfunction

endpackage

// File: rtl/shift_frame_ctrl_bit_timer.sv
// Bit-period timer: counts DIV clocks while running and strobes on the last one.
module bit_timer
   import shift_frame_pkg::*;
#(
   parameter int DIV = DEF_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic strobe
);

   localparam int            CW   = div_cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         div_cnt_reg <= '0;
      end else if (run) begin
         div_cnt_reg <= (div_cnt_reg == LAST) ? '0 : div_cnt_reg + 1'b1;
      end
   end

   assign strobe = run && (div_cnt_reg == LAST);

endmodule

// File: rtl/shift_frame_ctrl.sv
// Full-duplex serial frame sequencer: shifts a word out MSB-first while capturing ser_in.
// Optional trailing even-parity bit period is enabled by defining SHIFT_FRAME_PARITY_EN.
module shift_frame_ctrl
   import shift_frame_pkg::*;
#(
   parameter int   WIDTH      = DEF_WIDTH,
   parameter int   DIV        = DEF_DIV,
   parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             ser_out,
   input  logic             ser_in,
   output logic             bit_strobe,
   output logic             busy,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_perr
);

`ifdef SHIFT_FRAME_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int            BW        = $clog2(FRAME_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] sr_reg;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] rx_data_reg;
   logic [BW-1:0]    bit_cnt_reg;
   logic             ser_out_reg;
   logic             rx_valid_reg;
   logic             rx_perr_reg;
   logic             handshake;
   logic             shifting;
   logic             strobe;
`ifdef SHIFT_FRAME_PARITY_EN
   localparam logic [BW-1:0] PAR_IDX = BW'(WIDTH);
   logic             tx_par_reg;
`endif

   assign tx_ready  = ((state_reg == IDLE) || (state_reg == DONE)) && !rst;
   assign handshake = tx_valid && tx_ready;
   assign shifting  = (state_reg == SHIFT) && !rst;
   assign sr_next   = {sr_reg[WIDTH-2:0], ser_in};

   bit_timer #(.DIV(DIV)) u_bit_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (shifting),
      .restart(handshake),
      .strobe (strobe)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         sr_reg       <= '0;
         bit_cnt_reg  <= '0;
         ser_out_reg  <= IDLE_LEVEL;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         rx_perr_reg  <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
         tx_par_reg   <= 1'b0;
`endif
      end else begin
         rx_valid_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               state_reg <= IDLE;
               if (handshake) begin
                  state_reg   <= SHIFT;
                  sr_reg      <= tx_data;
                  bit_cnt_reg <= '0;
                  ser_out_reg <= tx_data[WIDTH-1];
`ifdef SHIFT_FRAME_PARITY_EN
                  tx_par_reg  <= ^tx_data;
`endif
               end
            end
            SHIFT: begin
               if (strobe) begin
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
`ifdef SHIFT_FRAME_PARITY_EN
                  // The parity strobe leaves sr holding the received word.
                  if (bit_cnt_reg == PAR_IDX) begin
                     state_reg    <= DONE;
                     ser_out_reg  <= IDLE_LEVEL;
                     rx_valid_reg <= 1'b1;
                     rx_data_reg  <= sr_reg;
                     rx_perr_reg  <= ser_in ^ (^sr_reg);
                  end else begin
                     sr_reg      <= sr_next;
                     ser_out_reg <= (bit_cnt_reg == LAST_DATA) ? tx_par_reg : sr_reg[WIDTH-2];
                  end
`else
                  sr_reg <= sr_next;
                  if (bit_cnt_reg == LAST_DATA) begin
                     state_reg    <= DONE;
                     ser_out_reg  <= IDLE_LEVEL;
                     rx_valid_reg <= 1'b1;
                     rx_data_reg  <= sr_next;
                  end else begin
                     ser_out_reg <= sr_reg[WIDTH-2];
                  end
`endif
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ser_out    = ser_out_reg;
   assign bit_strobe = strobe;
   assign busy       = shifting;
   assign rx_data    = rx_data_reg;
   assign rx_valid   = rx_valid_reg;
   assign rx_perr    = rx_perr_reg;

endmodule
